// File: rtl/mux_operand_seq.sv
// mux_operand_seq: collects operands A then B over one handshake bus,
// then presents them to the 2:1 mux and sweeps sel through 0 and 1.
module mux_operand_seq #(
    parameter int DW   = 4,
    parameter int HOLD = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic          sel,
    output logic          out_valid,
    output logic          done
);

    typedef enum logic [1:0] {
        S_A,
        S_B,
        SEL0,
        SEL1
    } state_t;

    localparam logic [3:0] LAST = 4'(HOLD - 1);

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic [DW-1:0] a_nxt;
    logic [DW-1:0] b_nxt;
    logic          sel_nxt;
    logic          cnt_last;

    assign cnt_last = (cnt == LAST);

    // Handshake and strobes decode from registered state/counter only.
    assign in_ready  = (state == S_A) || (state == S_B);
    assign out_valid = (state == SEL0) || (state == SEL1);
    assign done      = (state == SEL1) && cnt_last;

    // Next-state, operand capture and phase counter; clear overrides all.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        a_nxt     = a;
        b_nxt     = b;
        unique case (state)
            S_A: begin
                if (in_valid) begin
                    a_nxt     = in_data;
                    state_nxt = S_B;
                end
            end
            S_B: begin
                if (in_valid) begin
                    b_nxt     = in_data;
                    cnt_nxt   = '0;
                    state_nxt = SEL0;
                end
            end
            SEL0: begin
                if (cnt_last) begin
                    cnt_nxt   = '0;
                    state_nxt = SEL1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            SEL1: begin
                if (cnt_last) begin
                    cnt_nxt   = '0;
                    state_nxt = S_A;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_A;
            end
        endcase
        if (clear) begin
            state_nxt = S_A;
            cnt_nxt   = '0;
            a_nxt     = a;
            b_nxt     = b;
        end
        sel_nxt = (state_nxt == SEL1);
    end

    // State, counter, operand and select registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_A;
            cnt   <= '0;
            a     <= '0;
            b     <= '0;
            sel   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            sel   <= sel_nxt;
        end
    end

endmodule

// File: tb/tb_mux_operand_seq.sv
// tb_mux_operand_seq: drives a HOLD=2 and a HOLD=1 instance from one bus
// and compares both against a sweep-position reference model.
module tb_mux_operand_seq;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic            in_valid;
    logic [3:0]      in_data;
    logic [1:0]      ir;
    logic [1:0]      ov;
    logic [1:0]      sl;
    logic [1:0]      dn;
    logic [1:0][3:0] a_o;
    logic [1:0][3:0] b_o;

    int nchk  = 0;
    int nfail = 0;

    // Reference: t = position within sweep (0 = accepting operands).
    int         t      [2];
    bit         have_a [2];
    logic [3:0] ma     [2];
    logic [3:0] mb     [2];

    mux_operand_seq #(.DW(4), .HOLD(2)) u_h2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir[0]),
        .a(a_o[0]), .b(b_o[0]), .sel(sl[0]),
        .out_valid(ov[0]), .done(dn[0])
    );

    mux_operand_seq #(.DW(4), .HOLD(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(ir[1]),
        .a(a_o[1]), .b(b_o[1]), .sel(sl[1]),
        .out_valid(ov[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Reference model update at each rising edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                t[i]      <= 0;
                have_a[i] <= 1'b0;
                ma[i]     <= 4'h0;
                mb[i]     <= 4'h0;
            end else if (clear) begin
                t[i]      <= 0;
                have_a[i] <= 1'b0;
            end else if (t[i] == 0) begin
                if (in_valid && !have_a[i]) begin
                    ma[i]     <= in_data;
                    have_a[i] <= 1'b1;
                end else if (in_valid) begin
                    mb[i]     <= in_data;
                    have_a[i] <= 1'b0;
                    t[i]      <= 1;
                end
            end else if (t[i] == 2 * hold(i)) begin
                t[i] <= 0;
            end else begin
                t[i] <= t[i] + 1;
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] d, input logic c);
        in_valid = v;
        in_data  = d;
        clear    = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic [11:0] e;
        logic [11:0] o;
        rst_n = 1'b0;
        repeat (3) cyc(1'b1, 4'hF, 1'b0);
        rst_n = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nchk++;
            o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
            if (o !== 12'b1000_0000_0000) begin
                nfail++;
                $display("FAIL reset inst%0d: got %h want 800", i, o);
            end
        end
        cyc(1'b0, 4'hF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            nchk++;
            e = {t[i] == 0, t[i] != 0, t[i] > hold(i),
                 t[i] == 2 * hold(i), ma[i], mb[i]};
            o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
            if (o !== e) begin
                nfail++;
                $display("FAIL reset_model inst%0d: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_basic;
        logic [11:0] e;
        logic [11:0] o;
        logic [3:0]  y;
        logic [3:0]  ye [4];
        ye = '{4'b1010, 4'b1010, 4'b0001, 4'b0001};
        cyc(1'b1, 4'b1010, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        for (int j = 0; j < 4; j++) begin
            y = sl[0] ? b_o[0] : a_o[0];
            nchk++;
            if ({ov[0], sl[0], dn[0], y} !== {1'b1, j >= 2, j == 3, ye[j]}) begin
                nfail++;
                $display("FAIL basic c%0d: ov/sel/done/y %b%b%b %b want %b%b%b %b",
                         j, ov[0], sl[0], dn[0], y, 1'b1, j >= 2, j == 3, ye[j]);
            end
            for (int i = 0; i < 2; i++) begin
                nchk++;
                e = {t[i] == 0, t[i] != 0, t[i] > hold(i),
                     t[i] == 2 * hold(i), ma[i], mb[i]};
                o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
                if (o !== e) begin
                    nfail++;
                    $display("FAIL basic_model inst%0d: got %h want %h", i, o, e);
                end
            end
            cyc(1'b0, 4'h0, 1'b0);
        end
        nchk++;
        if ({ir[0], ov[0]} !== 2'b10) begin
            nfail++;
            $display("FAIL basic_ready: ir/ov %b%b want 10", ir[0], ov[0]);
        end
    endtask

    task automatic test_backpressure;
        logic [11:0] e;
        logic [11:0] o;
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'h5, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc(1'b0, 4'hE, 1'b0);
            nchk++;
            if ({ir[0], ov[0]} !== 2'b10) begin
                nfail++;
                $display("FAIL gap c%0d: ir/ov %b%b want 10", j, ir[0], ov[0]);
            end
            for (int i = 0; i < 2; i++) begin
                nchk++;
                e = {t[i] == 0, t[i] != 0, t[i] > hold(i),
                     t[i] == 2 * hold(i), ma[i], mb[i]};
                o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
                if (o !== e) begin
                    nfail++;
                    $display("FAIL gap_model inst%0d: got %h want %h", i, o, e);
                end
            end
        end
        cyc(1'b1, 4'h3, 1'b0);
        nchk++;
        if ({ov[0], sl[0], a_o[0], b_o[0]} !== {2'b10, 4'h5, 4'h3}) begin
            nfail++;
            $display("FAIL gap_start: ov/sel %b%b a %h b %h want 10 5 3",
                     ov[0], sl[0], a_o[0], b_o[0]);
        end
        repeat (5) cyc(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_held_valid;
        logic [11:0] e;
        logic [11:0] o;
        int          idx;
        int          st[$];
        logic [3:0]  pa[$];
        logic [3:0]  pb[$];
        logic        prev;
        bit          x;
        cyc(1'b0, 4'h0, 1'b1);
        idx  = 0;
        prev = ov[0];
        for (int n = 0; n < 24; n++) begin
            x = ir[0] && (idx < 4);
            cyc(idx < 4, 4'(idx + 1), 1'b0);
            if (x) idx++;
            for (int i = 0; i < 2; i++) begin
                nchk++;
                e = {t[i] == 0, t[i] != 0, t[i] > hold(i),
                     t[i] == 2 * hold(i), ma[i], mb[i]};
                o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
                if (o !== e) begin
                    nfail++;
                    $display("FAIL held_model inst%0d: got %h want %h", i, o, e);
                end
            end
            if (ov[0] && !prev) begin
                st.push_back(n);
                pa.push_back(a_o[0]);
                pb.push_back(b_o[0]);
            end
            prev = ov[0];
        end
        nchk++;
        if (st.size() != 2) begin
            nfail++;
            $display("FAIL held_count: sweeps %0d want 2", st.size());
        end else begin
            nchk++;
            if (st[1] - st[0] != 6 || {pa[0], pb[0], pa[1], pb[1]} !== 16'h1234) begin
                nfail++;
                $display("FAIL held_pairs: gap %0d pairs %h%h %h%h want 6 12 34",
                         st[1] - st[0], pa[0], pb[0], pa[1], pb[1]);
            end
        end
    endtask

    task automatic test_clear;
        logic [11:0] e;
        logic [11:0] o;
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'b1010, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b0, 4'h0, 1'b0);
        cyc(1'b0, 4'h0, 1'b0);
        nchk++;
        if ({ov[0], sl[0], dn[0]} !== 3'b110) begin
            nfail++;
            $display("FAIL clr_pre: ov/sel/done %b%b%b want 110", ov[0], sl[0], dn[0]);
        end
        cyc(1'b1, 4'hF, 1'b1);
        nchk++;
        if ({ir[0], ov[0], dn[0], a_o[0], b_o[0]} !== {3'b100, 4'b1010, 4'b0001}) begin
            nfail++;
            $display("FAIL clr_post: ir/ov/done %b%b%b a %h b %h want 100 a 1",
                     ir[0], ov[0], dn[0], a_o[0], b_o[0]);
        end
        cyc(1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            nchk++;
            e = {t[i] == 0, t[i] != 0, t[i] > hold(i),
                 t[i] == 2 * hold(i), ma[i], mb[i]};
            o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
            if (o !== e) begin
                nfail++;
                $display("FAIL clr_model inst%0d: got %h want %h", i, o, e);
            end
        end
        nchk++;
        if (a_o[0] !== 4'b1010) begin
            nfail++;
            $display("FAIL clr_discard: a %h want a", a_o[0]);
        end
    endtask

    task automatic test_hold1;
        cyc(1'b0, 4'h0, 1'b1);
        cyc(1'b1, 4'h7, 1'b0);
        cyc(1'b1, 4'h9, 1'b0);
        nchk++;
        if ({ov[1], sl[1], dn[1], a_o[1], b_o[1]} !== {3'b100, 4'h7, 4'h9}) begin
            nfail++;
            $display("FAIL h1_c1: ov/sel/done %b%b%b a %h b %h want 100 7 9",
                     ov[1], sl[1], dn[1], a_o[1], b_o[1]);
        end
        cyc(1'b0, 4'h0, 1'b0);
        nchk++;
        if ({ov[1], sl[1], dn[1]} !== 3'b111) begin
            nfail++;
            $display("FAIL h1_c2: ov/sel/done %b%b%b want 111", ov[1], sl[1], dn[1]);
        end
        cyc(1'b0, 4'h0, 1'b0);
        nchk++;
        if ({ir[1], ov[1], dn[1]} !== 3'b100) begin
            nfail++;
            $display("FAIL h1_c3: ir/ov/done %b%b%b want 100", ir[1], ov[1], dn[1]);
        end
    endtask

    task automatic test_random;
        logic [11:0] e;
        logic [11:0] o;
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            cyc($urandom_range(0, 9) < 7, 4'($urandom), $urandom_range(0, 24) == 0);
            for (int i = 0; i < 2; i++) begin
                nchk++;
                e = {t[i] == 0, t[i] != 0, t[i] > hold(i),
                     t[i] == 2 * hold(i), ma[i], mb[i]};
                o = {ir[i], ov[i], sl[i], dn[i], a_o[i], b_o[i]};
                if (o !== e) begin
                    nfail++;
                    $display("FAIL rand_model n%0d inst%0d: got %h want %h", n, i, o, e);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_held_valid();
        test_clear();
        test_hold1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/mux_operand_seq.md
# mux_operand_seq

Operand sequencer that sits directly upstream of the 4-bit 2-to-1 mux stage. It accepts two operands, A then B, over a shared input bus using a valid/ready handshake. It then holds them stable on the mux's `a`/`b` inputs and sweeps `sel` through 0 and 1, holding each value for a programmable number of cycles, with a valid strobe for the downstream consumer. It replaces hand-written stimulus with a reusable, clocked operand source for the mux datapath.

## Interface
- `DW`, 4: operand width; equals the mux data width.
- `HOLD`, 2: cycles each `sel` phase is presented; legal range 1..15.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous reset, active-low
- `clear`  in  1  synchronous abort; returns the FSM to S_A and keeps the `a`/`b` registers
- `in_data`  in  DW  shared operand bus
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block can accept an operand this cycle
- `a`  out  DW  operand A to the mux
- `b`  out  DW  operand B to the mux
- `sel`  out  1  mux select
- `out_valid`  out  1  `a`/`b`/`sel` form a valid mux input this cycle
- `done`  out  1  one-cycle pulse on the final cycle of the sweep

## Operation
- Moore FSM with four states.
  - S_A: `in_ready`=1. On a transfer, load `a` from `in_data` and go to S_B.
  - S_B: `in_ready`=1. On a transfer, load `b` from `in_data`, clear the counter, and go to SEL0.
  - SEL0: `sel`=0, `out_valid`=1. The counter increments each cycle. On `cnt==HOLD-1`, clear the counter and go to SEL1.
  - SEL1: `sel`=1, `out_valid`=1. On `cnt==HOLD-1`, assert `done` and go to S_A.
- Transfer definition: `in_valid & in_ready` sampled at the rising edge. `in_data` is ignored when no transfer occurs.
- `in_ready`, `out_valid` and `done` are decoded from the registered state and counter only. They have no combinational path from any input.
- `a`, `b` and `sel` are registers. `sel`=0 in S_A, S_B and SEL0.
- `a` and `b` change only on their own transfer and hold through the whole sweep and afterwards.
- Counter: 4 bits, counts 0..HOLD-1 and never exceeds HOLD-1. With `HOLD`=1, each phase lasts exactly one cycle.
- No operand is accepted during SEL0 or SEL1, because `in_ready`=0 there. Upstream must hold `in_valid` and `in_data` until it sees `in_ready`.

## Timing
- Reset (`rst_n`=0 at an edge) produces, from the next cycle:
  - state=S_A, `a`=0, `b`=0, `sel`=0, counter=0;
  - `out_valid`=0, `done`=0, `in_ready`=1.
- No transfer is taken at any edge where `rst_n`=0.
- Priority per edge: `rst_n` > `clear` > normal operation.
  - `clear`=1 forces state=S_A and counter=0, with `a`/`b` unchanged.
  - A transfer coinciding with `clear` is discarded.
- Latency: B is accepted at edge k. Then `out_valid`=1 and `sel`=0 for cycles k+1..k+HOLD, and `sel`=1 for cycles k+HOLD+1..k+2·HOLD.
- `done`=1 only in cycle k+2·HOLD. `in_ready`=1 again in cycle k+2·HOLD+1.
- Back-to-back operation: with `in_valid` held high, a new A is accepted at the first edge of S_A. The minimum period per operand pair is 2+2·HOLD cycles.
- Reset or `clear` mid-sweep drops `out_valid` and `done` in the very next cycle. No partial `done` is produced.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1 and `in_data`=4'hF. After release: `a`=0, `b`=0, `sel`=0, `out_valid`=0, `in_ready`=1, and no operand loaded.
- Basic sweep, `HOLD`=2: send A=4'b1010, then B=4'b0001.
  - `sel` reads 0,0,1,1 with `out_valid`=1 over those four cycles.
  - `done` is high only in the 4th cycle.
  - `in_ready`=1 in the following cycle.
  - The downstream mux output is 1010,1010,0001,0001.
- Backpressure gaps: `in_valid` is asserted for A, then deasserted for 3 cycles, then asserted with B=4'h3.
  - The FSM stays in S_B with `in_ready`=1 and `out_valid`=0 during the gap.
  - The sweep starts the cycle after B is accepted.
- Held `in_valid`: a continuous stream 4'h1,4'h2,4'h3,4'h4 produces two sweeps, (a=1,b=2) then (a=3,b=4), 6 cycles apart (`HOLD`=2). Data offered during a sweep is not consumed.
- `clear` in the first SEL1 cycle:
  - `out_valid`=0 and `done`=0 in the next cycle, with `in_ready`=1.
  - `a`=1010 and `b`=0001 are retained.
  - A transfer presented in the same cycle as `clear` is not loaded.
- `HOLD`=1 build: the A/B pair produces `sel` 0 then 1 in consecutive cycles, and `done` in the second cycle.
